sweep_tester: RTL and testbench
===============================

// Module: sweep_tester
//
// PURPOSE
// Upstream stimulus/response stage for the evolved-circuit test top.
// Drives the 5-bit data inputs and the 5-bit circuit select of the
// multiplexed circuit bank. Steps through every input vector, samples the
// single selected output bit and builds the circuit's full truth table.
// Compares that table to an expected table and reports pass/fail, the
// mismatch count and the first failing vector. This replaces manual switch
// toggling on the board.
//
// PARAMETERS
// IN_BITS        5  width of stim; the sweep covers 2**IN_BITS vectors
// SETTLE_CYCLES  4  cycles to wait after each stim change before sampling (>=1)
// SAMPLES        3  consecutive samples per vector, majority voted (odd, >=1)
//
// PORTS
// clk           in   1             system clock
// rst           in   1             synchronous, active-high reset
// start         in   1             1-cycle request to begin a sweep
// circuit_sel   in   5             circuit to test, latched on start
// expected      in   2**IN_BITS    expected truth table, latched on start
// dut_out       in   1             selected circuit output (bank mux result)
// stim          out  IN_BITS       input vector driven to the circuit bank
// sel_out       out  5             latched circuit_sel driven to the bank mux
// busy          out  1             sweep in progress
// done          out  1             1-cycle pulse when the sweep completes
// pass          out  1             1 when last sweep had zero mismatches
// signature     out  2**IN_BITS    captured truth table, bit k = response to stim k
// mism_cnt      out  IN_BITS+1     number of mismatching vectors in last sweep
// first_fail    out  IN_BITS       lowest mismatching vector (0 if none)
// unstable_cnt  out  IN_BITS+1     vectors whose samples disagreed (saturating)
//
// BEHAVIOUR
// - Reset: state IDLE. All outputs are 0: stim, sel_out, busy, done, pass,
//   signature, mism_cnt, first_fail, unstable_cnt.
// - rst has priority over all other inputs. A reset mid-sweep aborts the
//   sweep and gives reset values on the next edge. No done pulse is issued.
// - FSM states: IDLE -> SETTLE -> SAMPLE -> RECORD -> (SETTLE | DONE) -> IDLE.
// - IDLE: on start=1, latch circuit_sel and expected.
//   - Clear signature, mism_cnt, first_fail, unstable_cnt and pass.
//   - Set stim=0 and busy=1, then enter SETTLE.
//   - start while not IDLE is ignored, and the latched values are unchanged.
// - SETTLE: lasts exactly SETTLE_CYCLES cycles, with stim held.
// - SAMPLE: lasts exactly SAMPLES cycles. Sample dut_out each cycle and
//   count the ones.
//   - maj = (ones*2 > SAMPLES).
//   - If 0 < ones < SAMPLES, increment unstable_cnt (saturating at all-ones).
// - RECORD (1 cycle):
//   - Set signature[stim] = maj.
//   - If maj != expected[stim], increment mism_cnt. If this is the first
//     mismatch, set first_fail = stim.
//   - If stim is all-ones, go to DONE. Otherwise stim++ and go to SETTLE.
// - DONE (1 cycle):
//   - done=1, busy=0, pass = (mism_cnt==0).
//   - Then go to IDLE.
//   - Results hold until the next accepted start or rst.
// - Per-vector period P = SETTLE_CYCLES + SAMPLES + 1.
// - Timing: with start accepted at edge t, stim=0 is valid from t+1 and
//   done is high in cycle t + 1 + P*2**IN_BITS.
// - Defaults give P=8; done is high at t+257.
// - stim changes only on the RECORD->SETTLE edge, so no sample is taken in
//   the cycle stim changes.
// - sel_out is constant for the whole sweep.
// - A start in the same cycle as DONE is ignored. A start in IDLE the cycle
//   after DONE is accepted.
//
// TESTING
// 1. Default params, dut_out=stim[0], expected=32'hAAAAAAAA, start at t
//    -> done at t+257, pass=1, mism_cnt=0, signature=32'hAAAAAAAA, busy low with done.
// 2. Same model, expected=32'hAAAAAAAA ^ (1<<5) ^ (1<<20)
//    -> mism_cnt=2, first_fail=5, pass=0, signature=32'hAAAAAAAA.
// 3. dut_out forced 1,0,1 across the SAMPLE cycles of stim=3, otherwise 0,
//    expected=0 -> signature=32'h8, unstable_cnt=1, mism_cnt=1, first_fail=3.
// 4. circuit_sel=17, start; at stim=6 pulse start with circuit_sel=2
//    -> sel_out stays 17, sweep completes at t+257 unaffected.
// 5. rst high for 1 cycle while stim=10 -> next cycle all outputs 0, no done.
//    New start -> normal complete sweep matching scenario 1.
// 6. SETTLE_CYCLES=1, SAMPLES=1, IN_BITS=2, dut_out=&stim, expected=4'h8
//    -> done at t+13, signature=4'h8, pass=1.

Source files
------------

// File: rtl/sweep_tester.sv
// Truth-table sweeper: steps stim through every vector, majority-votes the
// selected circuit output, and compares the captured table to an expected one.
module sweep_tester #(
    parameter int IN_BITS       = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              circuit_sel,
    input  logic [2**IN_BITS-1:0]   expected,
    input  logic                    dut_out,
    output logic [IN_BITS-1:0]      stim,
    output logic [4:0]              sel_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [2**IN_BITS-1:0]   signature,
    output logic [IN_BITS:0]        mism_cnt,
    output logic [IN_BITS-1:0]      first_fail,
    output logic [IN_BITS:0]        unstable_cnt
);

    localparam int NVEC = 2**IN_BITS;
    localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int OW   = $clog2(SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_RECORD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OW-1:0]       ones_q, ones_d;
    logic [IN_BITS-1:0]  stim_q, stim_d;
    logic [4:0]          sel_q, sel_d;
    logic [NVEC-1:0]     exp_q, exp_d;
    logic [NVEC-1:0]     sig_q, sig_d;
    logic [IN_BITS:0]    mism_q, mism_d;
    logic [IN_BITS-1:0]  ff_q, ff_d;
    logic [IN_BITS:0]    unst_q, unst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                maj;
    logic                unstable;

    always_comb begin
        maj      = (int'(ones_q) * 2) > SAMPLES;
        unstable = (ones_q != '0) && (int'(ones_q) != SAMPLES);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        stim_d  = stim_q;
        sel_d   = sel_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        mism_d  = mism_q;
        ff_d    = ff_q;
        unst_d  = unst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = circuit_sel;
                    exp_d   = expected;
                    sig_d   = '0;
                    mism_d  = '0;
                    ff_d    = '0;
                    unst_d  = '0;
                    pass_d  = 1'b0;
                    stim_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(SAMPLES - 1);
                    ones_d  = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                ones_d = ones_q + OW'(dut_out);
                if (cnt_q == '0) begin
                    state_d = S_RECORD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RECORD: begin
                sig_d[stim_q] = maj;
                if (unstable && (unst_q != '1)) begin
                    unst_d = unst_q + (IN_BITS+1)'(1);
                end
                if (maj != exp_q[stim_q]) begin
                    mism_d = mism_q + (IN_BITS+1)'(1);
                    if (mism_q == '0) begin
                        ff_d = stim_q;
                    end
                end
                if (stim_q == '1) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mism_d == '0);
                    state_d = S_DONE;
                end else begin
                    stim_d  = stim_q + IN_BITS'(1);
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            stim_q  <= '0;
            sel_q   <= '0;
            exp_q   <= '0;
            sig_q   <= '0;
            mism_q  <= '0;
            ff_q    <= '0;
            unst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            stim_q  <= stim_d;
            sel_q   <= sel_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            mism_q  <= mism_d;
            ff_q    <= ff_d;
            unst_q  <= unst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim         = stim_q;
    assign sel_out      = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign signature    = sig_q;
    assign mism_cnt     = mism_q;
    assign first_fail   = ff_q;
    assign unstable_cnt = unst_q;

endmodule

// File: tb/tb_sweep_tester.sv
// Bench for sweep_tester: directed and random sweeps against a truth-table
// model, plus a reduced-parameter instance for the short-sweep timing case.
module tb_sweep_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  circuit_sel = '0;
    logic [31:0] expected = '0;
    logic        dut_out;
    logic [4:0]  stim;
    logic [4:0]  sel_out;
    logic        busy, done, pass;
    logic [31:0] signature;
    logic [5:0]  mism_cnt;
    logic [4:0]  first_fail;
    logic [5:0]  unstable_cnt;

    logic        sm_start = 1'b0;
    logic        sm_dut_out;
    logic [1:0]  sm_stim;
    logic [4:0]  sm_sel_out;
    logic        sm_busy, sm_done, sm_pass;
    logic [3:0]  sm_signature;
    logic [2:0]  sm_mism_cnt;
    logic [1:0]  sm_first_fail;
    logic [2:0]  sm_unstable_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 1000000;

    // Circuit-under-test model: response table plus per-sample flip masks.
    logic [31:0] resp = '0;
    logic [2:0]  noise [32];

    logic [31:0] m_sig;
    int          m_mism, m_ff, m_unst;
    logic        m_pass;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int p, pk, ph;
    always_comb begin
        p = cyc - t0;
        pk = 0;
        ph = 0;
        dut_out = resp[stim];
        if (p >= 0 && p < 256) begin
            pk = p / 8;
            ph = p % 8;
            if (ph >= 4 && ph <= 6) dut_out = resp[stim] ^ noise[pk][ph-4];
        end
    end

    assign sm_dut_out = &sm_stim;

    sweep_tester u_dut (
        .clk(clk), .rst(rst), .start(start), .circuit_sel(circuit_sel),
        .expected(expected), .dut_out(dut_out), .stim(stim), .sel_out(sel_out),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .mism_cnt(mism_cnt), .first_fail(first_fail), .unstable_cnt(unstable_cnt)
    );

    sweep_tester #(.IN_BITS(2), .SETTLE_CYCLES(1), .SAMPLES(1)) u_small (
        .clk(clk), .rst(rst), .start(sm_start), .circuit_sel(5'd3),
        .expected(4'h8), .dut_out(sm_dut_out), .stim(sm_stim), .sel_out(sm_sel_out),
        .busy(sm_busy), .done(sm_done), .pass(sm_pass), .signature(sm_signature),
        .mism_cnt(sm_mism_cnt), .first_fail(sm_first_fail), .unstable_cnt(sm_unstable_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] exp_tab);
        int ones;
        logic mj;
        m_sig = '0; m_mism = 0; m_ff = 0; m_unst = 0;
        for (int k = 0; k < 32; k++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) ones += int'(resp[k] ^ noise[k][j]);
            mj = (ones >= 2);
            m_sig[k] = mj;
            if (ones > 0 && ones < 3) m_unst++;
            if (mj != exp_tab[k]) begin
                if (m_mism == 0) m_ff = k;
                m_mism++;
            end
        end
        m_pass = (m_mism == 0);
    endfunction

    task automatic chk_reset(input string pre);
        chk({pre, "_stim"}, 64'(stim), 64'd0);
        chk({pre, "_sel_out"}, 64'(sel_out), 64'd0);
        chk({pre, "_busy"}, 64'(busy), 64'd0);
        chk({pre, "_done"}, 64'(done), 64'd0);
        chk({pre, "_pass"}, 64'(pass), 64'd0);
        chk({pre, "_signature"}, 64'(signature), 64'd0);
        chk({pre, "_mism_cnt"}, 64'(mism_cnt), 64'd0);
        chk({pre, "_first_fail"}, 64'(first_fail), 64'd0);
        chk({pre, "_unstable_cnt"}, 64'(unstable_cnt), 64'd0);
    endtask

    // ev_kind: 0 none, 1 stray start at ev_p, 2 reset at ev_p
    task automatic run_sweep(input string tag, input logic [4:0] sel,
                             input logic [31:0] exp_tab, input int ev_p, input int ev_kind);
        int got;
        int late_done;
        model(exp_tab);
        circuit_sel = sel;
        expected = exp_tab;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        circuit_sel = 5'($urandom);
        expected = $urandom;
        chk({tag, "_stim0"}, 64'(stim), 64'd0);
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        got = -1;
        for (int n = 1; n <= 400; n++) begin
            if (cyc - t0 == ev_p) begin
                if (ev_kind == 1) begin
                    chk({tag, "_stim_at_ev"}, 64'(stim), 64'(ev_p / 8));
                    start = 1'b1;
                    circuit_sel = 5'd2;
                    expected = ~exp_tab;
                end else if (ev_kind == 2) begin
                    chk({tag, "_stim_at_ev"}, 64'(stim), 64'(ev_p / 8));
                    rst = 1'b1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst = 1'b0;
            if (ev_kind == 2 && n == ev_p + 1) begin
                chk_reset({tag, "_abort"});
                late_done = 0;
                repeat (300) begin
                    @(posedge clk); #1;
                    if (done) late_done++;
                end
                chk({tag, "_no_done_after_rst"}, 64'(late_done), 64'd0);
                return;
            end
            if (ev_kind == 1 && n == ev_p + 1)
                chk({tag, "_sel_hold"}, 64'(sel_out), 64'(sel));
            if (done) begin
                got = n;
                break;
            end
        end
        chk({tag, "_done_latency"}, 64'(got), 64'd256);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_signature"}, 64'(signature), 64'(m_sig));
        chk({tag, "_mism_cnt"}, 64'(mism_cnt), 64'(m_mism));
        chk({tag, "_first_fail"}, 64'(first_fail), 64'(m_ff));
        chk({tag, "_unstable_cnt"}, 64'(unstable_cnt), 64'(m_unst));
        chk({tag, "_pass"}, 64'(pass), 64'(m_pass));
        chk({tag, "_sel_out"}, 64'(sel_out), 64'(sel));
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_start_in_done_ignored"}, 64'(busy), 64'd0);
        chk({tag, "_done_pulse_len"}, 64'(done), 64'd0);
        chk({tag, "_result_hold"}, 64'(signature), 64'(m_sig));
    endtask

    initial begin
        int got;
        for (int k = 0; k < 32; k++) noise[k] = 3'b000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        chk("reset_small_busy", 64'(sm_busy), 64'd0);
        chk("reset_small_sig", 64'(sm_signature), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        resp = 32'hAAAAAAAA;
        run_sweep("s1_match", 5'd9, 32'hAAAAAAAA, -10, 0);
        run_sweep("s2_two_mism", 5'd9, 32'hAAAAAAAA ^ (32'd1 << 5) ^ (32'd1 << 20), -10, 0);

        resp = 32'h0;
        noise[3] = 3'b101;
        run_sweep("s3_unstable", 5'd4, 32'h0, -10, 0);
        noise[3] = 3'b000;

        resp = 32'hAAAAAAAA;
        run_sweep("s4_stray_start", 5'd17, 32'hAAAAAAAA, 48, 1);
        run_sweep("s5_reset", 5'd12, 32'hAAAAAAAA, 83, 2);
        run_sweep("s5_after_rst", 5'd12, 32'hAAAAAAAA, -10, 0);

        for (int r = 0; r < 4; r++) begin
            resp = $urandom;
            for (int k = 0; k < 32; k++)
                noise[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            run_sweep($sformatf("rand%0d", r), 5'($urandom),
                      (r == 0) ? resp : $urandom, -10, 0);
        end
        for (int k = 0; k < 32; k++) noise[k] = 3'b000;

        sm_start = 1'b1;
        @(posedge clk); #1;
        sm_start = 1'b0;
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (sm_done) begin
                got = n;
                break;
            end
        end
        chk("s6_done_latency", 64'(got), 64'd12);
        chk("s6_signature", 64'(sm_signature), 64'h8);
        chk("s6_pass", 64'(sm_pass), 64'd1);
        chk("s6_mism_cnt", 64'(sm_mism_cnt), 64'd0);
        chk("s6_sel_out", 64'(sm_sel_out), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
